// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode map, FSM step
// enumeration, opcode classes, bit positions inside the packed ctrl word and ALU codes.
// Opcode 11001 is reserved and decodes as undefined.
package cpu_ctrl_pkg;

   // Opcode map, IR[31:27]
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_IN   = 5'b10100;
   localparam logic [4:0] OP_OUT  = 5'b10101;
   localparam logic [4:0] OP_MFHI = 5'b10110;
   localparam logic [4:0] OP_MFLO = 5'b10111;
   localparam logic [4:0] OP_NOP  = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11010;

   // ALU select used for address and branch-target arithmetic
   localparam logic [4:0] OPS_ADD = 5'b00011;

   // Bit positions of the strobes inside ctrl
   localparam int unsigned C_PCOUT     = 0;
   localparam int unsigned C_PCIN      = 1;
   localparam int unsigned C_INCPC     = 2;
   localparam int unsigned C_MARIN     = 3;
   localparam int unsigned C_MDRIN     = 4;
   localparam int unsigned C_MDROUT    = 5;
   localparam int unsigned C_IRIN      = 6;
   localparam int unsigned C_READ      = 7;
   localparam int unsigned C_WRITE     = 8;
   localparam int unsigned C_RYIN      = 9;
   localparam int unsigned C_RZIN      = 10;
   localparam int unsigned C_RZLOOUT   = 11;
   localparam int unsigned C_RZHIOUT   = 12;
   localparam int unsigned C_HIIN      = 13;
   localparam int unsigned C_LOIN      = 14;
   localparam int unsigned C_HIOUT     = 15;
   localparam int unsigned C_LOOUT     = 16;
   localparam int unsigned C_GRA       = 17;
   localparam int unsigned C_GRB       = 18;
   localparam int unsigned C_GRC       = 19;
   localparam int unsigned C_RIN       = 20;
   localparam int unsigned C_ROUT      = 21;
   localparam int unsigned C_BAOUT     = 22;
   localparam int unsigned C_COUT      = 23;
   localparam int unsigned C_CONIN     = 24;
   localparam int unsigned C_PORTIN    = 25;
   localparam int unsigned C_INPORTOUT = 26;

   typedef enum logic [3:0] {
      StReset, StFetch0, StFetch1, StFetch2, StT3, StT4, StT5, StT6, StT7, StPause, StHalt
   } state_e;

   typedef enum logic [3:0] {
      ClsAlu, ClsUnary, ClsImm, ClsMulDiv, ClsLdi, ClsLd, ClsSt, ClsBr,
      ClsJr, ClsMfhi, ClsMflo, ClsIn, ClsOut, ClsNop, ClsHalt, ClsIllegal
   } op_class_e;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode -> instruction class decode for the control sequencer.
// Macro IO_EN: when defined, in/out decode to their own classes; otherwise they are
// undefined opcodes.
module opcode_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] opcode_i,
   output op_class_e  op_class_o
);

   // Map each opcode to the step sequence class it runs in T3..T7
   always_comb begin
      op_class_o = ClsIllegal;
      case (opcode_i)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL,
         OP_ROR, OP_ROL, OP_AND, OP_OR:    op_class_o = ClsAlu;
         OP_NEG, OP_NOT:                   op_class_o = ClsUnary;
         OP_ADDI, OP_ANDI, OP_ORI:         op_class_o = ClsImm;
         OP_MUL, OP_DIV:                   op_class_o = ClsMulDiv;
         OP_LDI:                           op_class_o = ClsLdi;
         OP_LD:                            op_class_o = ClsLd;
         OP_ST:                            op_class_o = ClsSt;
         OP_BR:                            op_class_o = ClsBr;
         OP_JR:                            op_class_o = ClsJr;
         OP_MFHI:                          op_class_o = ClsMfhi;
         OP_MFLO:                          op_class_o = ClsMflo;
`ifdef IO_EN
         OP_IN:                            op_class_o = ClsIn;
         OP_OUT:                           op_class_o = ClsOut;
`endif
         OP_NOP:                           op_class_o = ClsNop;
         OP_HALT:                          op_class_o = ClsHalt;
         default:                          op_class_o = ClsIllegal;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath: fetch, decode of
// IR[31:27], per-class T3..T7 step sequences, memory-ready stalls, pause and halt.
// Macro IO_EN: enables the in/out instructions; otherwise PORTin/InPortOut are tied 0.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned CTRL_W = 27,
   parameter int unsigned OPS_W  = 5
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [4:0]        ir_opcode,
   input  logic              con_ff,
   input  logic              mem_ready,
   input  logic              stop,
   output logic [CTRL_W-1:0] ctrl,
   output logic [OPS_W-1:0]  ops,
   output logic              run,
   output logic              illegal_op
);

   state_e    state_q, state_d;
   logic      f1_wait_q, f1_wait_d;  // set while FETCH1 is past its entry cycle
   logic      illegal_q, illegal_d;
   op_class_e op_class;

   opcode_class_decode u_decode (
      .opcode_i   (ir_opcode),
      .op_class_o (op_class)
   );

   // Next step selection
   always_comb begin
      state_d   = state_q;
      f1_wait_d = 1'b0;
      illegal_d = illegal_q;
      unique case (state_q)
         StReset:  state_d = StFetch0;
         StFetch0: state_d = stop ? StPause : StFetch1;
         StPause:  if (!stop) state_d = StFetch0;
         StFetch1: begin
            if (mem_ready) state_d = StFetch2;
            else           f1_wait_d = 1'b1;
         end
         StFetch2: state_d = StT3;
         StT3: begin
            case (op_class)
               ClsAlu, ClsUnary, ClsImm, ClsMulDiv,
               ClsLdi, ClsLd, ClsSt, ClsBr:          state_d = StT4;
               ClsHalt:                              state_d = StHalt;
               ClsIllegal: begin
                  state_d   = StFetch0;
                  illegal_d = 1'b1;
               end
               default:                              state_d = StFetch0;
            endcase
         end
         StT4: state_d = (op_class == ClsUnary) ? StFetch0 : StT5;
         StT5: begin
            case (op_class)
               ClsMulDiv, ClsLd, ClsSt, ClsBr: state_d = StT6;
               default:                        state_d = StFetch0;
            endcase
         end
         StT6: begin
            case (op_class)
               ClsLd:   state_d = mem_ready ? StT7 : StT6;
               ClsSt:   state_d = StT7;
               default: state_d = StFetch0;
            endcase
         end
         StT7: state_d = (op_class == ClsSt && !mem_ready) ? StT7 : StFetch0;
         StHalt: state_d = StHalt;
         default: state_d = StReset;
      endcase
   end

   // Step register plus sticky flags; clear wins over any step, including memory waits
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= StReset;
         f1_wait_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         f1_wait_q <= f1_wait_d;
         illegal_q <= illegal_d;
      end
   end

   // Strobes and ALU select decoded from the current step and opcode class
   always_comb begin
      ctrl = '0;
      ops  = '0;
      run  = 1'b1;
      unique case (state_q)
         StReset, StPause, StHalt: run = 1'b0;
         StFetch0: begin
            if (!stop) begin
               ctrl[C_PCOUT] = 1'b1; ctrl[C_MARIN] = 1'b1;
               ctrl[C_INCPC] = 1'b1; ctrl[C_RZIN]  = 1'b1;
            end
         end
         StFetch1: begin
            ctrl[C_READ] = 1'b1; ctrl[C_MDRIN] = 1'b1;
            // PC update only once per fetch, however long memory stalls
            if (!f1_wait_q) begin
               ctrl[C_RZLOOUT] = 1'b1; ctrl[C_PCIN] = 1'b1;
            end
         end
         StFetch2: begin
            ctrl[C_MDROUT] = 1'b1; ctrl[C_IRIN] = 1'b1;
         end
         StT3: begin
            case (op_class)
               ClsAlu, ClsImm: begin
                  ctrl[C_GRB] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_RYIN] = 1'b1;
               end
               ClsUnary: begin
                  ctrl[C_GRB] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_RZIN] = 1'b1;
                  ops = OPS_W'(ir_opcode);
               end
               ClsMulDiv: begin
                  ctrl[C_GRA] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_RYIN] = 1'b1;
               end
               ClsLdi, ClsLd, ClsSt: begin
                  ctrl[C_GRB] = 1'b1; ctrl[C_BAOUT] = 1'b1; ctrl[C_RYIN] = 1'b1;
               end
               ClsBr: begin
                  ctrl[C_GRA] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_CONIN] = 1'b1;
               end
               ClsJr: begin
                  ctrl[C_GRA] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_PCIN] = 1'b1;
               end
               ClsMfhi: begin
                  ctrl[C_HIOUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1;
               end
               ClsMflo: begin
                  ctrl[C_LOOUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1;
               end
`ifdef IO_EN
               ClsIn: begin
                  ctrl[C_INPORTOUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1;
               end
               ClsOut: begin
                  ctrl[C_GRA] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_PORTIN] = 1'b1;
               end
`endif
               default: ;
            endcase
         end
         StT4: begin
            case (op_class)
               ClsAlu: begin
                  ctrl[C_GRC] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_RZIN] = 1'b1;
                  ops = OPS_W'(ir_opcode);
               end
               ClsUnary: begin
                  ctrl[C_RZLOOUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1;
               end
               ClsImm: begin
                  ctrl[C_COUT] = 1'b1; ctrl[C_RZIN] = 1'b1;
                  ops = OPS_W'(ir_opcode);
               end
               ClsMulDiv: begin
                  ctrl[C_GRB] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_RZIN] = 1'b1;
                  ops = OPS_W'(ir_opcode);
               end
               ClsLdi, ClsLd, ClsSt: begin
                  ctrl[C_COUT] = 1'b1; ctrl[C_RZIN] = 1'b1;
                  ops = OPS_W'(OPS_ADD);
               end
               ClsBr: begin
                  ctrl[C_PCOUT] = 1'b1; ctrl[C_RYIN] = 1'b1;
               end
               default: ;
            endcase
         end
         StT5: begin
            case (op_class)
               ClsAlu, ClsImm, ClsLdi: begin
                  ctrl[C_RZLOOUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1;
               end
               ClsMulDiv: begin
                  ctrl[C_RZLOOUT] = 1'b1; ctrl[C_LOIN] = 1'b1;
               end
               ClsLd, ClsSt: begin
                  ctrl[C_RZLOOUT] = 1'b1; ctrl[C_MARIN] = 1'b1;
               end
               ClsBr: begin
                  ctrl[C_COUT] = 1'b1; ctrl[C_RZIN] = 1'b1;
                  ops = OPS_W'(OPS_ADD);
               end
               default: ;
            endcase
         end
         StT6: begin
            case (op_class)
               ClsMulDiv: begin
                  ctrl[C_RZHIOUT] = 1'b1; ctrl[C_HIIN] = 1'b1;
               end
               ClsLd: begin
                  ctrl[C_READ] = 1'b1; ctrl[C_MDRIN] = 1'b1;
               end
               ClsSt: begin
                  ctrl[C_GRA] = 1'b1; ctrl[C_ROUT] = 1'b1; ctrl[C_MDRIN] = 1'b1;
               end
               ClsBr: begin
                  ctrl[C_RZLOOUT] = 1'b1;
                  ctrl[C_PCIN]    = con_ff;
               end
               default: ;
            endcase
         end
         StT7: begin
            case (op_class)
               ClsLd: begin
                  ctrl[C_MDROUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_RIN] = 1'b1;
               end
               ClsSt: ctrl[C_WRITE] = 1'b1;
               default: ;
            endcase
         end
         default: run = 1'b0;
      endcase
`ifndef IO_EN
      ctrl[C_PORTIN]    = 1'b0;
      ctrl[C_INPORTOUT] = 1'b0;
`endif
   end

   assign illegal_op = illegal_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired Moore control unit that drives the existing single-bus datapath's per-step control strobes.
- Fetches: PC→MAR, increment, memory read, MDR→IR.
- Decodes the 5-bit opcode from IR[31:27] and runs the T3..T7 step sequence for that opcode class.
- Stalls on a memory-ready handshake; stops on halt.
- Replaces the hand-coded step sequences the team currently writes in benches.

Parameters:
CTRL_W, 27, width of packed control word (bit map in shared package)
OPS_W, 5, ALU operation select width

Ports:
clock  input  1  system clock, all state changes on rising edge
clear  input  1  synchronous active-high reset
ir_opcode  input  5  IR[31:27], stable from first cycle after FETCH2
con_ff  input  1  branch condition flip-flop output from datapath
mem_ready  input  1  memory has completed current Read/Write this cycle
stop  input  1  pause request, sampled only in FETCH0
ctrl  output  CTRL_W  packed strobes: PCout PCin IncPC MARin MDRin MDRout IRin Read Write RYin RZin RZLOout RZHIout HIin LOin HIout LOout gra grb grc rin rout BAout cout conin PORTin InPortOut
ops  output  OPS_W  ALU operation select
run  output  1  high while executing; low in RESET_ST, PAUSE, HALT
illegal_op  output  1  sticky, set on undefined opcode

Behaviour:
- Reset: clock edge with clear=1 → RESET_ST regardless of state, including mid-instruction or mid-wait.
  - RESET_ST: ctrl=0, ops=0, run=0, illegal_op=0.
  - Next edge with clear=0 → FETCH0.
- Outputs are pure decode of current state plus ir_opcode/con_ff. No output registers, zero latency.
- Any strobe not listed for a state is 0. ops=0 unless listed. ADD code = 5'b00011.
- FETCH0: if stop=1, go to PAUSE (run=0, ctrl=0; leave when stop=0 → FETCH0). Otherwise assert PCout MARin IncPC RZin → FETCH1.
- FETCH1: assert RZLOout PCin only on entry cycle. Assert Read MDRin every cycle. Hold until mem_ready=1, then → FETCH2. PCin must pulse exactly once per fetch.
- FETCH2: MDRout IRin → T3.
- ALU reg-reg (add sub shr shl ror rol and or):
  - T3: grb rout RYin.
  - T4: grc rout RZin, ops=ir_opcode.
  - T5: RZLOout gra rin.
- Unary (neg not):
  - T3: grb rout RZin, ops=ir_opcode.
  - T4: RZLOout gra rin.
- Immediate (addi andi ori):
  - T3: grb rout RYin.
  - T4: cout RZin, ops=ir_opcode.
  - T5: RZLOout gra rin.
- mul/div:
  - T3: gra rout RYin.
  - T4: grb rout RZin, ops=ir_opcode.
  - T5: RZLOout LOin.
  - T6: RZHIout HIin.
- ldi:
  - T3: grb BAout RYin.
  - T4: cout RZin, ops=ADD.
  - T5: RZLOout gra rin.
- ld:
  - T3–T4: as ldi.
  - T5: RZLOout MARin.
  - T6: Read MDRin; wait until mem_ready.
  - T7: MDRout gra rin.
- st:
  - T3–T5: as ld.
  - T6: gra rout MDRin.
  - T7: Write; wait until mem_ready.
- br:
  - T3: gra rout conin.
  - T4: PCout RYin.
  - T5: cout RZin, ops=ADD.
  - T6: RZLOout, PCin only if con_ff=1 (sampled in T6).
- Single-step instructions, each T3 only:
  - jr: gra rout PCin.
  - mfhi: HIout gra rin.
  - mflo: LOout gra rin.
- nop: T3 all zero.
- Last step of every class → FETCH0.
- halt: → HALT, run=0, ctrl=0. Left only by clear.
- Undefined opcode: set illegal_op, treat as nop.
- Memory waits have no timeout. mem_ready high in the same cycle as state entry completes the wait in one cycle.

Optional Feature:
IO_EN
- Defined: in and out are decoded.
  - in: T3 InPortOut gra rin.
  - out: T3 gra rout PORTin.
- Undefined: in/out are undefined opcodes (illegal_op set, nop). InPortOut and PORTin are tied 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants (ld=00000 … halt=11010);
  - state enumeration;
  - ctrl bit-index constants;
  - OPS_ADD.
- One sub-module, opcode_class_decode (combinational opcode→class), is natural. The FSM stays in control_sequencer.

Test Plan:
- clear=1 two cycles, then 0 → ctrl=0, run=0 during clear; FETCH0 strobes (PCout MARin IncPC RZin) on first post-clear cycle.
- add R1,R2,R3 (opcode 00011), mem_ready tied 1 → 6 cycles per instruction; T4 ops=5'b00011 with grc rout RZin; T5 gra rin.
- br, con_ff=1 then 0 → T6 PCin=1 in the first case, 0 in the second; 7 cycles each; conin pulses only in T3.
- ld with mem_ready low 3 cycles in T6 → Read/MDRin held 4 cycles; T7 MDRout gra rin; PCin pulsed once in fetch.
- clear asserted during st T7 wait → RESET_ST next edge, Write drops to 0 immediately.
- opcode 11111, then halt → illegal_op=1 stays set; after halt run=0 and ctrl=0 indefinitely; stop=1 at FETCH0 → PAUSE until released.
